// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes by fixed priority plus a
// redirect-vs-I-cache-miss tracker. Optional cycle counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EX_DH_Stall,
  input  logic        ID_MEM1_DH_Stall,
  input  logic        ID_MEM2_DH_Stall,
  input  logic        IF_ICacheBusy,
  input  logic        MEM_DCacheBusy,
  input  logic        EXE_DivBusy,
  input  logic        MEM_ExceptFlush,
  input  logic        EXE_BranchFlush,
  output logic        PC_Wr,
  output logic        ID_Wr,
  output logic        EXE_Wr,
  output logic        MEM_Wr,
  output logic        MEM2_Wr,
  output logic        WB_Wr,
  output logic        ID_Flush,
  output logic        EXE_Flush,
  output logic        MEM_Flush,
  output logic        ID_DisWr,
  output logic        Redirect_Pending
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] Perf_DHStallCnt,
  output logic [31:0] Perf_ICStallCnt,
  output logic [31:0] Perf_DCStallCnt
`endif
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT_IC = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [1:0] w_state_eff;
  logic       w_dh;
  logic       w_redirect_ic;

  assign w_dh          = ID_EX_DH_Stall | ID_MEM1_DH_Stall | ID_MEM2_DH_Stall;
  assign w_redirect_ic = (MEM_ExceptFlush | EXE_BranchFlush) & IF_ICacheBusy;
  // While reset is held the outputs behave as if already back in RUN.
  assign w_state_eff   = rst ? ST_RUN : r_state;

  // Stage enables and clears: priority chain, then pending-redirect override.
  always_comb begin
    PC_Wr     = 1'b1;
    ID_Wr     = 1'b1;
    EXE_Wr    = 1'b1;
    MEM_Wr    = 1'b1;
    MEM2_Wr   = 1'b1;
    WB_Wr     = 1'b1;
    ID_Flush  = 1'b0;
    EXE_Flush = 1'b0;
    MEM_Flush = 1'b0;
    ID_DisWr  = 1'b0;
    if (MEM_DCacheBusy) begin
      PC_Wr   = 1'b0;
      ID_Wr   = 1'b0;
      EXE_Wr  = 1'b0;
      MEM_Wr  = 1'b0;
      MEM2_Wr = 1'b0;
      WB_Wr   = 1'b0;
    end else if (MEM_ExceptFlush) begin
      ID_Flush  = 1'b1;
      EXE_Flush = 1'b1;
      MEM_Flush = 1'b1;
    end else if (EXE_DivBusy) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EXE_Wr    = 1'b0;
      MEM_Flush = 1'b1;
    end else if (EXE_BranchFlush) begin
      ID_Flush = 1'b1;
    end else if (w_dh) begin
      PC_Wr    = 1'b0;
      ID_Wr    = 1'b0;
      ID_DisWr = 1'b1;
    end else if (IF_ICacheBusy) begin
      PC_Wr    = 1'b0;
      ID_Flush = 1'b1;
    end else begin
      PC_Wr = 1'b1;
    end
    // The stale fetch of an interrupted redirect must never reach ID.
    if (!MEM_DCacheBusy) begin
      case (w_state_eff)
        ST_WAIT_IC: begin
          PC_Wr    = 1'b0;
          ID_Flush = 1'b1;
        end
        ST_DISCARD: ID_Flush = 1'b1;
        default:    ID_Flush = ID_Flush;
      endcase
    end else begin
      ID_Flush = 1'b0;
    end
  end

  assign Redirect_Pending = (w_state_eff == ST_WAIT_IC);

  // Next-state selection; a D-cache stall freezes the tracker.
  always_comb begin
    w_state_next = r_state;
    if (MEM_DCacheBusy) begin
      w_state_next = r_state;
    end else begin
      case (r_state)
        ST_RUN:     w_state_next = w_redirect_ic ? ST_WAIT_IC : ST_RUN;
        ST_WAIT_IC: w_state_next = IF_ICacheBusy ? ST_WAIT_IC : ST_DISCARD;
        ST_DISCARD: w_state_next = w_redirect_ic ? ST_WAIT_IC : ST_RUN;
        default:    w_state_next = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_dh_cnt;
  logic [31:0] r_ic_cnt;
  logic [31:0] r_dc_cnt;
  logic        w_dh_sel;
  logic        w_ic_sel;

  assign w_dh_sel = w_dh & ~MEM_DCacheBusy & ~MEM_ExceptFlush & ~EXE_DivBusy & ~EXE_BranchFlush;
  assign w_ic_sel = ~MEM_DCacheBusy & ((IF_ICacheBusy & ~w_dh & ~MEM_ExceptFlush &
                    ~EXE_DivBusy & ~EXE_BranchFlush) | (w_state_eff == ST_WAIT_IC));

  // Free-running stall-cycle counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dh_cnt <= 32'd0;
      r_ic_cnt <= 32'd0;
      r_dc_cnt <= 32'd0;
    end else begin
      r_dh_cnt <= r_dh_cnt + {31'd0, w_dh_sel};
      r_ic_cnt <= r_ic_cnt + {31'd0, w_ic_sel};
      r_dc_cnt <= r_dc_cnt + {31'd0, MEM_DCacheBusy};
    end
  end

  assign Perf_DHStallCnt = r_dh_cnt;
  assign Perf_ICStallCnt = r_ic_cnt;
  assign Perf_DCStallCnt = r_dc_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: priority table plus redirect/reset sequences.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic dh_ex, dh_m1, dh_m2, ic, dc, div, exc, br;
  logic pc_wr, id_wr, exe_wr, mem_wr, mem2_wr, wb_wr;
  logic id_fl, exe_fl, mem_fl, id_dis, pend;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .ID_EX_DH_Stall(dh_ex), .ID_MEM1_DH_Stall(dh_m1), .ID_MEM2_DH_Stall(dh_m2),
    .IF_ICacheBusy(ic), .MEM_DCacheBusy(dc), .EXE_DivBusy(div),
    .MEM_ExceptFlush(exc), .EXE_BranchFlush(br),
    .PC_Wr(pc_wr), .ID_Wr(id_wr), .EXE_Wr(exe_wr), .MEM_Wr(mem_wr),
    .MEM2_Wr(mem2_wr), .WB_Wr(wb_wr),
    .ID_Flush(id_fl), .EXE_Flush(exe_fl), .MEM_Flush(mem_fl),
    .ID_DisWr(id_dis), .Redirect_Pending(pend)
  );

  // Expected word: {PC,ID,EXE,MEM,MEM2,WB wr ; ID,EXE,MEM flush ; DisWr ; Pending}
  localparam logic [10:0] E_DEF = {6'b111111, 3'b000, 1'b0, 1'b0};
  localparam logic [10:0] E_DH  = {6'b001111, 3'b000, 1'b1, 1'b0};
  localparam logic [10:0] E_IC  = {6'b011111, 3'b100, 1'b0, 1'b0};
  localparam logic [10:0] E_DC  = {6'b000000, 3'b000, 1'b0, 1'b0};
  localparam logic [10:0] E_EXC = {6'b111111, 3'b111, 1'b0, 1'b0};
  localparam logic [10:0] E_DIV = {6'b000111, 3'b001, 1'b0, 1'b0};
  localparam logic [10:0] E_BR  = {6'b111111, 3'b100, 1'b0, 1'b0};
  localparam logic [10:0] E_WIC = {6'b011111, 3'b100, 1'b0, 1'b1};
  localparam logic [10:0] E_DCW = {6'b000000, 3'b000, 1'b0, 1'b1};
  localparam logic [10:0] E_WEX = {6'b011111, 3'b111, 1'b0, 1'b1};

  typedef struct {
    logic [2:0]  dh;
    logic        ic, dc, div, exc, br;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[13];
  logic [10:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
  task automatic step(input logic r, input logic [2:0] d, input logic i, input logic c,
                      input logic v, input logic x, input logic b,
                      input logic [10:0] e, input string nm);
    logic [10:0] got;
    logic [10:0] want;
    string       wn;
    @(posedge clk);
    #1;
    rst = r; {dh_ex, dh_m1, dh_m2} = d; ic = i; dc = c; div = v; exc = x; br = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    got  = {pc_wr, id_wr, exe_wr, mem_wr, mem2_wr, wb_wr, id_fl, exe_fl, mem_fl, id_dis, pend};
    want = exp_q.pop_front();
    wn   = name_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", wn, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; {dh_ex, dh_m1, dh_m2, ic, dc, div, exc, br} = 8'd0;
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "idle"};
    vecs[1]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DH,  "dh_ex"};
    vecs[2]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DH,  "dh_mem2"};
    vecs[3]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IC,  "ic_only"};
    vecs[4]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_DC,  "dc_exc_dh"};
    vecs[5]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_EXC, "exc_only"};
    vecs[6]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_DIV, "div_only"};
    vecs[7]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_DIV, "div_br"};
    vecs[8]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_BR,  "br_only"};
    vecs[9]  = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_DH,  "dh_over_ic"};
    vecs[10] = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, E_DC,  "dc_br_ic"};
    vecs[11] = '{3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_DIV, "div_over_dh"};
    vecs[12] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_EXC, "exc_over_div"};

    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "reset_idle");
    step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_BR,  "reset_redirect");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "after_reset");

    for (int k = 0; k < 13; k++)
      step(1'b0, vecs[k].dh, vecs[k].ic, vecs[k].dc, vecs[k].div, vecs[k].exc, vecs[k].br,
           vecs[k].exp, vecs[k].name);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "table_still_run");

    // Two-cycle load-use stall then release.
    step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DH,  "dh_m1_c1");
    step(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DH,  "dh_m1_c2");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "dh_m1_c3");

    // Branch redirect during an I-cache miss, one discard, back to run.
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_BR,  "redir_c1");
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_WIC, "wait_c2");
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_WIC, "wait_c3");
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_WIC, "wait_c4");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_WIC, "wait_release");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BR,  "discard");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "back_run");

    // Redirect in WAIT_IC, D-stall freeze, redirect from DISCARD.
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_BR,  "redir2");
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_WEX, "exc_in_wait");
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_DCW, "dc_in_wait");
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_WIC, "wait_frozen");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_WIC, "wait_release2");
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_BR,  "discard_redir");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_WIC, "rewait");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BR,  "discard2");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "back_run2");

    // Redirect without I-cache miss stays in RUN.
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_EXC, "exc_no_ic");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "exc_no_ic_run");

    // Reset while waiting on the I-cache.
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_BR,  "redir3");
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_WIC, "wait3");
    step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IC,  "rst_in_wait");
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, "run_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Ports SHALL be: clk  in  1  sole clock, all state on rising edge.
REQ-002 Ports SHALL be: rst  in  1  synchronous, active-high reset.
REQ-003 Ports SHALL be: ID_EX_DH_Stall, ID_MEM1_DH_Stall, ID_MEM2_DH_Stall  in  1 each  load-use stalls from ID.
REQ-004 Ports SHALL be: IF_ICacheBusy  in  1  I-cache miss in progress.
REQ-005 Ports SHALL be: MEM_DCacheBusy  in  1  D-cache miss in progress.
REQ-006 Ports SHALL be: EXE_DivBusy  in  1  multicycle divider not done.
REQ-007 Ports SHALL be: MEM_ExceptFlush  in  1  exception/ERET redirect.
REQ-008 Ports SHALL be: EXE_BranchFlush  in  1  branch mispredict redirect.
REQ-009 Ports SHALL be: PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr  out  1 each  stage register enables.
REQ-010 Ports SHALL be: ID_Flush, EXE_Flush, MEM_Flush  out  1 each  stage register clears.
REQ-011 Ports SHALL be: ID_DisWr  out  1  bubble into EXE (kills ID write/load/store types).
REQ-012 Ports SHALL be: Redirect_Pending  out  1  high in state WAIT_IC.

Function
REQ-013 Outputs SHALL be combinational from inputs and state; default: all *_Wr=1, flushes=0, ID_DisWr=0.
REQ-014 Priority, highest first: MEM_DCacheBusy, MEM_ExceptFlush, EXE_DivBusy, EXE_BranchFlush, DH stalls (OR of three), IF_ICacheBusy.
REQ-015 MEM_DCacheBusy=1: all six *_Wr=0, no flush, ID_DisWr=0; pending state SHALL NOT change.
REQ-016 MEM_ExceptFlush=1 (no D-busy): ID_Flush=EXE_Flush=MEM_Flush=1, all *_Wr=1.
REQ-017 EXE_DivBusy=1 (none above): PC_Wr=ID_Wr=EXE_Wr=0, MEM_Flush=1.
REQ-018 EXE_BranchFlush=1 (none above): ID_Flush=1, all *_Wr=1.
REQ-019 Any DH stall (none above): PC_Wr=ID_Wr=0, ID_DisWr=1.
REQ-020 IF_ICacheBusy alone: PC_Wr=0, ID_Flush=1.
REQ-021 FSM states SHALL be RUN, WAIT_IC, DISCARD; reset state RUN.
REQ-022 RUN->WAIT_IC when (MEM_ExceptFlush or EXE_BranchFlush) and IF_ICacheBusy and not MEM_DCacheBusy.
REQ-023 WAIT_IC->DISCARD when IF_ICacheBusy=0; in WAIT_IC, PC_Wr=0, ID_Flush=1 regardless of REQ-014 except REQ-015.
REQ-024 DISCARD SHALL assert ID_Flush=1 for exactly one cycle (wrong-path fetch dropped), then ->RUN; a new redirect with IF_ICacheBusy in DISCARD ->WAIT_IC.
REQ-025 Redirect while already in WAIT_IC SHALL keep WAIT_IC (no extra discard).
REQ-026 Redirect without IF_ICacheBusy SHALL NOT leave RUN.

Reset
REQ-027 rst=1 at a clock edge SHALL force state RUN and clear counters, overriding all inputs, including mid WAIT_IC/DISCARD.
REQ-028 Outputs while rst=1 SHALL equal the RUN defaults for current inputs, Redirect_Pending=0.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN defined: SHALL add outputs Perf_DHStallCnt, Perf_ICStallCnt, Perf_DCStallCnt (32 bits each) counting cycles where REQ-019, REQ-020/WAIT_IC, REQ-015 apply; wrap 0xFFFFFFFF->0.
REQ-030 Macro undefined: counter ports and logic SHALL be absent; other behaviour identical.

Verification
REQ-031 ID_MEM1_DH_Stall=1 for 2 cycles -> PC_Wr=ID_Wr=0, ID_DisWr=1 both cycles; cycle 3 defaults.
REQ-032 MEM_DCacheBusy=1 with MEM_ExceptFlush=1 and ID_EX_DH_Stall=1 -> all *_Wr=0, no flush, state unchanged.
REQ-033 EXE_BranchFlush=1 with IF_ICacheBusy=1 for 4 cycles -> WAIT_IC, Redirect_Pending=1 for cycles 2-4; busy drops -> one DISCARD cycle with ID_Flush=1, then RUN.
REQ-034 In WAIT_IC assert rst for 1 cycle -> next cycle RUN, Redirect_Pending=0.
REQ-035 EXE_DivBusy=1 and EXE_BranchFlush=1 together -> PC_Wr=ID_Wr=EXE_Wr=0, MEM_Flush=1, ID_Flush=0.
REQ-036 With HAZARD_PERF_CNT_EN, Perf_DCStallCnt preset to 0xFFFFFFFF, one D-busy cycle -> reads 0.
